// File: rtl/booth_divider.sv
// Iterative radix-2 restoring 32/32 divider with valid/ready handshakes, signed or unsigned.
// Optional macro DIV_ZERO_EARLY_OUT_EN: a zero divisor skips the iteration and returns at once.
module booth_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   shifted, trial;

  // dvd_q holds the dividend magnitude and collects quotient bits from the LSB up.
  assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    x_d         = x_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div0_d      = div0_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          neg_quo_d = in_signed & (X[WIDTH-1] ^ Y[WIDTH-1]);
          neg_rem_d = in_signed & X[WIDTH-1];
          dvd_d     = (in_signed && X[WIDTH-1]) ? -X : X;
          dvs_d     = (in_signed && Y[WIDTH-1]) ? -Y : Y;
          rem_d     = '0;
          cnt_d     = '0;
          x_d       = X;
          div0_d    = (Y == '0);
`ifdef DIV_ZERO_EARLY_OUT_EN
          if (Y == '0) begin
            quo_d   = '1;
            rmd_d   = X;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
`else
          state_d   = StCalc;
`endif
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial;
        end else begin
          rem_d = shifted;
        end
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (div0_q) begin
          quo_d = '1;
          rmd_d = x_q;
        end else begin
          quo_d = neg_quo_q ? -dvd_q : dvd_q;
          rmd_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        // out_valid is registered, so it rises one edge after DONE is entered.
        if (out_valid_q && out_ready) begin
          state_d = StIdle;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      x_q         <= '0;
      quo_q       <= '0;
      rmd_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      x_q         <= x_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider: arithmetic cases, latency, handshake, reset.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] X;
  logic [31:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef DIV_ZERO_EARLY_OUT_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = 34;
`endif

  always #5 clk = ~clk;

  booth_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  // Present one operation, count edges from the accepting edge to out_valid, then consume it.
  // lat = -1 means the operands were not accepted or no result arrived in time.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    lat = -1;
    q   = 'x;
    r   = 'x;
    @(negedge clk);
    if (in_ready !== 1'b1) return;
    X = a; Y = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    X = 32'hDEAD_BEEF; Y = 32'h0BAD_F00D; in_signed = ~s;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    q = quotient;
    r = remainder;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    if (remainder !== 32'h0) begin bad++; $display("FAIL reset_remainder got=%h want=0", remainder); end
  endtask

  task automatic test_unsigned;
    logic [31:0] q, r;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, q, r, lat);
    total += 3;
    if (q !== 32'd14) begin bad++; $display("FAIL u100_7_q got=%h want=%h", q, 32'd14); end
    if (r !== 32'd2) begin bad++; $display("FAIL u100_7_r got=%h want=%h", r, 32'd2); end
    if (lat !== 34) begin bad++; $display("FAIL u100_7_latency got=%0d want=34", lat); end
  endtask

  task automatic test_signed;
    logic [31:0] q, r;
    int lat;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat);
    total += 2;
    if (q !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sm7_2_q got=%h want=fffffffd", q); end
    if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sm7_2_r got=%h want=ffffffff", r); end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, lat);
    total += 2;
    if (q !== 32'hFFFF_FFFD) begin bad++; $display("FAIL s7_m2_q got=%h want=fffffffd", q); end
    if (r !== 32'd1) begin bad++; $display("FAIL s7_m2_r got=%h want=1", r); end
  endtask

  task automatic test_overflow;
    logic [31:0] q, r;
    int lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat);
    total += 2;
    if (q !== 32'h8000_0000) begin bad++; $display("FAIL ovf_s_q got=%h want=80000000", q); end
    if (r !== 32'h0) begin bad++; $display("FAIL ovf_s_r got=%h want=0", r); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, lat);
    total += 2;
    if (q !== 32'h0) begin bad++; $display("FAIL ovf_u_q got=%h want=0", q); end
    if (r !== 32'h8000_0000) begin bad++; $display("FAIL ovf_u_r got=%h want=80000000", r); end
  endtask

  task automatic test_div_zero;
    logic [31:0] q, r;
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(32'h1234_5678, 32'h0, s[0], q, r, lat);
      total += 3;
      if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_q s=%0d got=%h want=ffffffff", s, q); end
      if (r !== 32'h1234_5678) begin bad++; $display("FAIL div0_r s=%0d got=%h want=12345678", s, r); end
      if (lat !== Div0Lat) begin bad++; $display("FAIL div0_latency s=%0d got=%0d want=%0d", s, lat, Div0Lat); end
    end
  endtask

  task automatic test_handshake;
    logic [31:0] q, r;
    int lat;
    bit seen;
    @(negedge clk);
    X = 32'd1000; Y = 32'd10; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL hs_out_valid_timeout got=0 want=1"); end
    // Hold the result for 10 cycles while pulsing in_valid with other operands.
    for (int i = 0; i < 10; i++) begin
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL hs_hold_valid c=%0d got=%b want=1", i, out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL hs_hold_in_ready c=%0d got=%b want=0", i, in_ready); end
      if (quotient !== 32'd100) begin bad++; $display("FAIL hs_hold_q c=%0d got=%h want=%h", i, quotient, 32'd100); end
      if (remainder !== 32'd0) begin bad++; $display("FAIL hs_hold_r c=%0d got=%h want=0", i, remainder); end
      in_valid = i[0];
      X = 32'd77 + i; Y = 32'd3; in_signed = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hs_release_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hs_release_in_ready got=%b want=1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL hs_release_busy got=%b want=0", busy); end
    // Next op starts right away after the result handshake.
    run_op(32'd50, 32'd5, 1'b0, q, r, lat);
    total += 3;
    if (q !== 32'd10) begin bad++; $display("FAIL b2b_q got=%h want=%h", q, 32'd10); end
    if (r !== 32'd0) begin bad++; $display("FAIL b2b_r got=%h want=0", r); end
    if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    int lat;
    @(negedge clk);
    X = 32'd100; Y = 32'd7; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    if (quotient !== 32'h0) begin bad++; $display("FAIL mid_rst_q got=%h want=0", quotient); end
    repeat (25) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_partial got=%b want=0", out_valid); end
    run_op(32'd9, 32'd3, 1'b0, q, r, lat);
    total += 2;
    if (q !== 32'd3) begin bad++; $display("FAIL post_rst_q got=%h want=3", q); end
    if (r !== 32'd0) begin bad++; $display("FAIL post_rst_r got=%h want=0", r); end
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    X         = '0;
    Y         = '0;
    out_ready = 1'b0;
    test_reset;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_handshake;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Iterative 32/32 divider; inverse companion to the Booth/Wallace 32x32 multiplier in the MDU.
- Accepts dividend X and divisor Y over a valid/ready handshake and runs radix-2 restoring division on magnitudes.
- Returns quotient and remainder over a second valid/ready handshake.
- Supports signed (truncating) and unsigned operation. HI/LO writeback logic consumes {remainder, quotient}.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset; sampled on rising clk edge only.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle and able to accept operands.
- in_signed  input  1  1 = signed two's-complement division, 0 = unsigned.
- X  input  WIDTH  dividend.
- Y  input  WIDTH  divisor.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient, truncated toward zero.
- remainder  output  WIDTH  remainder; takes the sign of the dividend.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (resetn=0 at an edge): state IDLE, in_ready=1 after reset, out_valid=0, quotient=0, remainder=0, busy=0, counter=0.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. A transfer happens when in_valid and in_ready are both high at an edge. On that edge:
  - latch sign_q = in_signed & (X[W-1] ^ Y[W-1]) and sign_r = in_signed & X[W-1];
  - load |X| and |Y| (absolute values only if in_signed, else raw);
  - clear partial remainder (W+1 bits) and counter;
  - go to CALC.
- CALC, one iteration per cycle, 32 cycles:
  - shift {rem, dividend} left by 1;
  - trial = rem_shifted - {0,|Y|};
  - if trial is non-negative, rem = trial and quotient LSB = 1; else restore and LSB = 0;
  - counter increments; after iteration WIDTH go to FIX.
- FIX:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r;
  - apply divide-by-zero override;
  - go to DONE.
- DONE: out_valid=1; quotient and remainder held stable until out_valid and out_ready are both high at an edge, then return to IDLE.
- Back-to-back operation: in_ready is 0 in DONE, so a new op is accepted no earlier than the cycle after the result handshake.
- Latency: out_valid rises at the (WIDTH+2)th edge after the accepting edge, i.e. 34 edges for WIDTH=32.
- Divide by zero (Y==0), any signedness: quotient = all ones (0xFFFFFFFF); remainder = X unmodified.
- Signed overflow (X=0x80000000, Y=0xFFFFFFFF, in_signed=1): quotient = 0x80000000, remainder = 0. Falls out of the magnitude path with no special case.
- in_valid while busy: ignored; X, Y and in_signed need not be held after acceptance.
- out_ready high while out_valid is low: no effect.

Optional Feature:
- Macro DIV_ZERO_EARLY_OUT_EN.
- Defined: when Y==0 at the accepting edge, skip CALC and FIX and go directly from IDLE to DONE with the divide-by-zero values loaded. out_valid rises 1 edge after acceptance.
- Undefined: divide by zero takes the full 34-edge latency; the override is applied in FIX.

Test Plan:
- Unsigned: X=100, Y=7, in_signed=0 -> quotient=14, remainder=2; out_valid rises exactly 34 edges after the accept edge.
- Signed sign mix: X=-7 (0xFFFFFFF9), Y=2, signed -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also X=7, Y=-2 -> quotient=-3, remainder=1.
- Overflow and unsigned large: X=0x80000000, Y=0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x80000000.
- Divide by zero: X=0x12345678, Y=0 (both signedness values) -> quotient=0xFFFFFFFF, remainder=0x12345678. Latency 34 edges without the macro, 1 edge with DIV_ZERO_EARLY_OUT_EN.
- Handshake: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, extra in_valid pulses ignored. Release out_ready -> IDLE next edge, then accept the next op.
- Reset mid-op: assert resetn=0 for one edge at iteration 15 -> out_valid=0, in_ready=1, busy=0 next cycle. A following op X=9, Y=3 gives quotient=3, remainder=0.
